// File: rtl/uart_inst_rx_pkg.sv
// Shared constants for the instruction-byte UART receiver: FSM encoding,
// default bit timing and 8N1 frame geometry.
package uart_inst_rx_pkg;

  localparam int CLKS_PER_BIT_DEF = 100;
  localparam int DATA_BITS        = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  // Serial data arrives LSB first, so each new bit enters at the top.
  function automatic logic [DATA_BITS-1:0] shift_in_lsb(
    input logic [DATA_BITS-1:0] i_sh,
    input logic                 i_bit
  );
    return {i_bit, i_sh[DATA_BITS-1:1]};
  endfunction

endpackage

// File: rtl/uart_inst_rx_sync2.sv
// Two-flop synchronizer that resets to 1 (idle-high lines such as RsRx, btnS, btnR).
module rx_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_inst_rx.sv
// 8N1 UART receiver delivering instruction bytes with a one-cycle valid strobe
// and a one-cycle framing-error strobe.
module uart_inst_rx
  import uart_inst_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RsRx,
  output logic [7:0] inst_wd,
  output logic       inst_vld,
  output logic       frm_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_HALF = CW'(HALF_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic [2:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [7:0]           r_wd;
  logic                 r_vld;
  logic                 r_err;
  logic                 r_busy;

  rx_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (RsRx),
    .o_q   (w_rx_s)
  );

  // Frame FSM; the cycle counter restarts at every sample point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_wd    <= 8'h00;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_START: begin
          if (r_cnt == LAST_HALF) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state <= ST_DATA;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == LAST_BIT) begin
            r_cnt   <= '0;
            r_shift <= shift_in_lsb(r_shift, w_rx_s);
            if (r_bit == LAST_DATA) begin
              r_state <= ST_STOP;
              r_bit   <= '0;
            end else begin
              r_bit   <= r_bit + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_cnt == LAST_BIT) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_wd    <= r_shift;
              r_vld   <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          // A held-low (break) line must return high before a new start is accepted.
          if (w_rx_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_WAIT_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_bit   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign inst_wd  = r_wd;
  assign inst_vld = r_vld;
  assign frm_err  = r_err;
  assign busy     = r_busy;

endmodule
